// File: rtl/ph_reg1_fifo_if.sv
// Register-1 parasite-to-host FIFO bus: parasite write side, host pop side, status.
`timescale 1ns/1ps
interface ph_reg1_fifo_if #(
    parameter int PTR_W = 5
);
    logic             p_select;
    logic             p_rdnw;
    logic [7:0]       p_data;
    logic             h_select;
    logic             h_rd;
    logic [7:0]       h_data;
    logic             h_data_available;
    logic             p_full;
    logic [PTR_W:0]   p_level;

    modport master (
        output p_select, p_rdnw, p_data, h_select, h_rd,
        input  h_data, h_data_available, p_full, p_level
    );

    modport slave (
        input  p_select, p_rdnw, p_data, h_select, h_rd,
        output h_data, h_data_available, p_full, p_level
    );
endinterface

// File: rtl/ph_reg1_fifo.sv
// Tube register-1 parasite-to-host byte FIFO across the asynchronous p_phi2/h_phi2 domains.
// Per-slot toggle flags give occupancy, so the depth need not be a power of two.
`timescale 1ns/1ps
module ph_reg1_fifo #(
    parameter int DEPTH       = 24,
    parameter int PTR_W       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic          h_rst_b,
    input  logic          h_phi2,
    input  logic          p_phi2,
    ph_reg1_fifo_if.slave bus
);
    logic [PTR_W-1:0]                   r_wptr, r_rptr;
    logic [DEPTH-1:0]                   r_wtog, r_rtog;
    logic [SYNC_STAGES-1:0][DEPTH-1:0]  r_wsync_h, r_rsync_p;
    logic [7:0]                         r_mem [DEPTH];

    logic [DEPTH-1:0]  w_rtog_p, w_wtog_h, w_occ_p;
    logic              w_full, w_avail, w_wr, w_rd;
    logic [PTR_W:0]    w_level;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_rtog_p = r_rsync_p[SYNC_STAGES-1];
    assign w_wtog_h = r_wsync_h[SYNC_STAGES-1];
    assign w_occ_p  = r_wtog ^ w_rtog_p;

    // Each side compares its own live toggle with the other's synchronised copy,
    // so a flag can only lag towards the safe direction.
    assign w_full  = w_occ_p[r_wptr];
    assign w_avail = w_wtog_h[r_rptr] ^ r_rtog[r_rptr];
    assign w_wr    = bus.p_select & ~bus.p_rdnw & ~w_full;
    assign w_rd    = bus.h_select & bus.h_rd & w_avail;

    always_comb begin
        w_level = '0;
        for (int i = 0; i < DEPTH; i++)
            w_level = w_level + (PTR_W+1)'(w_occ_p[i]);
    end

    // Parasite domain
    always_ff @(negedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            r_wptr    <= '0;
            r_wtog    <= '0;
            r_rsync_p <= '0;
        end else begin
            r_rsync_p <= {r_rsync_p[SYNC_STAGES-2:0], r_rtog};
            if (w_wr) begin
                r_wtog[r_wptr] <= ~r_wtog[r_wptr];
                r_wptr         <= f_inc(r_wptr);
            end
        end
    end

    // Storage is not reset; a slot is only read once its toggle has crossed over.
    always_ff @(negedge p_phi2) begin
        if (w_wr)
            r_mem[r_wptr] <= bus.p_data;
    end

    // Host domain
    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            r_rptr    <= '0;
            r_rtog    <= '0;
            r_wsync_h <= '0;
        end else begin
            r_wsync_h <= {r_wsync_h[SYNC_STAGES-2:0], r_wtog};
            if (w_rd) begin
                r_rtog[r_rptr] <= ~r_rtog[r_rptr];
                r_rptr         <= f_inc(r_rptr);
            end
        end
    end

    assign bus.h_data           = r_mem[r_rptr];
    assign bus.h_data_available = w_avail;
    assign bus.p_full           = w_full;
    assign bus.p_level          = w_level;
endmodule

// File: tb/tb_ph_reg1_fifo.sv
// Bench for ph_reg1_fifo: directed scenarios plus random traffic against a queue model
// that bounds the flags by synchroniser latency.
`timescale 1ns/1ps
module tb_ph_reg1_fifo;
    localparam int DEPTH = 24;
    localparam int PTR_W = 5;
    localparam int SYNC  = 2;

    logic h_rst_b = 1'b0;
    logic h_phi2  = 1'b0;
    logic p_phi2  = 1'b0;

    // 2 MHz host, ~3 MHz parasite; the parasite phase offset keeps falling edges apart.
    always #250 h_phi2 = ~h_phi2;
    initial begin
        #83;
        forever #167 p_phi2 = ~p_phi2;
    end

    ph_reg1_fifo_if #(.PTR_W(PTR_W)) bus ();

    ph_reg1_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .SYNC_STAGES(SYNC)) dut (
        .h_rst_b (h_rst_b),
        .h_phi2  (h_phi2),
        .p_phi2  (p_phi2),
        .bus     (bus)
    );

    int vecs  = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: bytes in flight, host-edge stamp of each write, parasite-edge stamp of recent pops
    logic [7:0] q[$];
    int         qts[$];
    int         popc[$];
    int         hc = 0, pc = 0;
    logic       av_prev = 1'b0, full_prev = 1'b0;

    always @(negedge h_rst_b) begin
        q.delete();
        qts.delete();
        popc.delete();
        av_prev   = 1'b0;
        full_prev = 1'b0;
    end

    always @(negedge h_phi2) begin
        hc++;
        if (h_rst_b && bus.h_select && bus.h_rd && av_prev && q.size() > 0) begin
            void'(q.pop_front());
            void'(qts.pop_front());
            popc.push_back(pc);
        end
        #1;
        if (!h_rst_b) begin
            chk("rst_avail", bus.h_data_available, 0);
        end else begin
            if (q.size() > 0 && hc - qts[0] >= SYNC + 1)
                chk("avail_latency", bus.h_data_available, 1);
            if (bus.h_data_available) begin
                chk("no_false_avail", q.size() != 0, 1);
                if (q.size() > 0)
                    chk("h_data_head", bus.h_data, q[0]);
            end
        end
        av_prev = bus.h_data_available;
    end

    always @(negedge p_phi2) begin
        pc++;
        if (h_rst_b && bus.p_select && !bus.p_rdnw && !full_prev) begin
            q.push_back(bus.p_data);
            qts.push_back(hc);
        end
        #1;
        while (popc.size() > 0 && pc - popc[0] >= SYNC + 1)
            void'(popc.pop_front());
        if (!h_rst_b) begin
            chk("rst_full", bus.p_full, 0);
            chk("rst_level", bus.p_level, 0);
        end else begin
            if (q.size() == DEPTH)
                chk("full_when_full", bus.p_full, 1);
            if (q.size() + popc.size() < DEPTH)
                chk("no_false_full", bus.p_full, 0);
            chk("level_lo", bus.p_level >= q.size(), 1);
            chk("level_hi", bus.p_level <= q.size() + popc.size(), 1);
        end
        full_prev = bus.p_full;
    end

    task automatic p_write(input logic [7:0] d);
        @(posedge p_phi2);
        bus.p_select = 1'b1;
        bus.p_rdnw   = 1'b0;
        bus.p_data   = d;
        @(posedge p_phi2);
        bus.p_select = 1'b0;
        bus.p_rdnw   = 1'b1;
    endtask

    task automatic h_pop(output logic [7:0] d, output logic av);
        @(posedge h_phi2);
        d  = bus.h_data;
        av = bus.h_data_available;
        bus.h_select = 1'b1;
        bus.h_rd     = 1'b1;
        @(posedge h_phi2);
        bus.h_select = 1'b0;
        bus.h_rd     = 1'b0;
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] exp);
        logic [7:0] d;
        logic       av;
        h_pop(d, av);
        chk({nm, "_avail"}, av, 1);
        chk(nm, d, exp);
    endtask

    task automatic wait_avail(input int maxe, output int n);
        n = 0;
        while (!bus.h_data_available && n < maxe) begin
            @(negedge h_phi2);
            #2;
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end before 2 ms");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       av;
        int         n;

        bus.p_select = 1'b0;
        bus.p_rdnw   = 1'b1;
        bus.p_data   = '0;
        bus.h_select = 1'b0;
        bus.h_rd     = 1'b0;

        // Reset with both clocks running
        repeat (3) @(posedge h_phi2);
        #1;
        chk("t1_avail", bus.h_data_available, 0);
        chk("t1_full",  bus.p_full, 0);
        chk("t1_level", bus.p_level, 0);
        @(posedge h_phi2);
        h_rst_b = 1'b1;
        repeat (4) @(posedge h_phi2);
        chk("t1_avail_rel", bus.h_data_available, 0);
        chk("t1_full_rel",  bus.p_full, 0);
        chk("t1_level_rel", bus.p_level, 0);

        // Single byte
        p_write(8'hA5);
        wait_avail(6, n);
        chk("t2_latency", n <= SYNC + 1, 1);
        chk("t2_avail", bus.h_data_available, 1);
        chk("t2_data", bus.h_data, 8'hA5);
        h_pop(d, av);
        chk("t2_pop_avail", av, 1);
        chk("t2_pop_data", d, 8'hA5);
        chk("t2_empty", bus.h_data_available, 0);

        // Fill to depth, overflow write discarded
        for (int i = 0; i < DEPTH; i++) p_write(8'(i));
        chk("t3_full", bus.p_full, 1);
        chk("t3_level", bus.p_level, 24);
        p_write(8'hFF);
        chk("t3_level_ovf", bus.p_level, 24);
        repeat (4) @(posedge h_phi2);
        for (int i = 0; i < DEPTH; i++) pop_expect("t3_order", 8'(i));
        chk("t3_empty", bus.h_data_available, 0);

        // Wrap across the last slot
        for (int i = 0; i < 20; i++) p_write(8'h80 + 8'(i));
        repeat (4) @(posedge h_phi2);
        for (int i = 0; i < 20; i++) pop_expect("t4_pre", 8'h80 + 8'(i));
        for (int i = 0; i < 10; i++) p_write(8'h40 + 8'(i));
        repeat (4) @(posedge h_phi2);
        for (int i = 0; i < 10; i++) pop_expect("t4_wrap", 8'h40 + 8'(i));
        chk("t4_empty", bus.h_data_available, 0);

        // Read while empty
        h_pop(d, av);
        chk("t5_empty_read", av, 0);
        chk("t5_still_empty", bus.h_data_available, 0);
        p_write(8'h3C);
        repeat (4) @(posedge h_phi2);
        pop_expect("t5_data", 8'h3C);

        // Reset mid-stream with both sides active
        for (int i = 0; i < 5; i++) p_write(8'h10 + 8'(i));
        @(posedge h_phi2);
        bus.h_select = 1'b1;
        bus.h_rd     = 1'b1;
        bus.p_select = 1'b1;
        bus.p_rdnw   = 1'b0;
        bus.p_data   = 8'h99;
        #100;
        h_rst_b = 1'b0;
        #1;
        chk("t6_avail", bus.h_data_available, 0);
        chk("t6_full",  bus.p_full, 0);
        chk("t6_level", bus.p_level, 0);
        bus.h_select = 1'b0;
        bus.h_rd     = 1'b0;
        bus.p_select = 1'b0;
        bus.p_rdnw   = 1'b1;
        repeat (2) @(posedge h_phi2);
        h_rst_b = 1'b1;
        p_write(8'h77);
        repeat (4) @(posedge h_phi2);
        pop_expect("t6_post_rst", 8'h77);

        // Random traffic: write-heavy then read-heavy
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    @(posedge p_phi2);
                    bus.p_select = ($urandom_range(0, 99) < ((i < 250) ? 70 : 20));
                    bus.p_rdnw   = ($urandom_range(0, 9) == 0);
                    bus.p_data   = 8'($urandom);
                end
                @(posedge p_phi2);
                bus.p_select = 1'b0;
                bus.p_rdnw   = 1'b1;
            end
            begin
                for (int i = 0; i < 340; i++) begin
                    @(posedge h_phi2);
                    bus.h_select = ($urandom_range(0, 99) < ((i < 170) ? 25 : 75));
                    bus.h_rd     = ($urandom_range(0, 7) != 0);
                end
                @(posedge h_phi2);
                bus.h_select = 1'b0;
                bus.h_rd     = 1'b0;
            end
        join

        repeat (6) @(posedge h_phi2);
        for (int k = 0; k < DEPTH + 2; k++)
            if (bus.h_data_available) h_pop(d, av);
        repeat (4) @(posedge h_phi2);
        chk("drain_empty", bus.h_data_available, 0);
        chk("drain_level", bus.p_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
